// File: rtl/systolic_skew_feeder_if.sv
// Feeder bus: FIFO-side inputs, array-side outputs and tile control.
interface systolic_skew_feeder_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 8,
    parameter int unsigned KW = 8
);
    logic            start;
    logic [KW-1:0]   k_len;
    logic [N-1:0]    aemptys;
    logic [N-1:0]    wemptys;
    logic [N*DW-1:0] as_in;
    logic [N*DW-1:0] ws_in;
    logic            read;
    logic [N*DW-1:0] a_out;
    logic [N*DW-1:0] w_out;
    logic [N-1:0]    a_vld;
    logic [N-1:0]    w_vld;
    logic            busy;
    logic            done;

    // Controller / bench side
    modport master (
        output start, k_len, aemptys, wemptys, as_in, ws_in,
        input  read, a_out, w_out, a_vld, w_vld, busy, done
    );

    // Feeder side
    modport slave (
        input  start, k_len, aemptys, wemptys, as_in, ws_in,
        output read, a_out, w_out, a_vld, w_vld, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Pops K beats from all 2N FIFOs in lockstep and skews lane i by i cycles
// to build the diagonal wavefront for an N x N systolic array.
module systolic_skew_feeder #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 8,
    parameter int unsigned KW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    systolic_skew_feeder_if.slave   bus
);
    localparam int unsigned DRW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_e;

    state_e         state_q, state_d;
    logic [KW-1:0]  kreg_q, kreg_d;
    logic [KW-1:0]  cnt_q, cnt_d;
    logic [DRW-1:0] drain_q, drain_d;
    logic           read_q;
    logic           done_q;
    logic           read_c;
    logic           busy_c;
    logic           fifos_ready_c;

    assign fifos_ready_c = ~|bus.aemptys & ~|bus.wemptys;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Tile bookkeeping: length, beat count, drain timer, pop and done delays
    always_ff @(posedge clk) begin
        if (rst) begin
            kreg_q  <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            read_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            kreg_q  <= kreg_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            read_q  <= read_c;
            done_q  <= (state_q == S_DONE);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.k_len == '0) ? S_DONE : S_FEED;
                end
            end
            S_FEED: begin
                if (read_c && (cnt_q + KW'(1) == kreg_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRW'(N)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath next values; drain timer parks at 0 while feeding
    always_comb begin
        read_c  = 1'b0;
        busy_c  = 1'b0;
        kreg_d  = kreg_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    kreg_d = bus.k_len;
                    cnt_d  = '0;
                end
            end
            S_FEED: begin
                busy_c  = 1'b1;
                read_c  = fifos_ready_c;
                drain_d = '0;
                if (fifos_ready_c) begin
                    cnt_d = cnt_q + KW'(1);
                end
            end
            S_DRAIN: begin
                busy_c  = 1'b1;
                drain_d = drain_q + DRW'(1);
            end
            default: begin
            end
        endcase
    end

    assign bus.read = read_c;
    assign bus.busy = busy_c;
    assign bus.done = done_q;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DW-1:0] a_q [0:gi];
        logic [DW-1:0] w_q [0:gi];
        logic [gi:0]   v_q;

        // Stage 0 takes the FIFO head one cycle after a pop (zero on a bubble), then gi delay stages
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= gi; j++) begin
                    a_q[j] <= '0;
                    w_q[j] <= '0;
                end
                v_q <= '0;
            end else begin
                a_q[0] <= read_q ? bus.as_in[gi*DW +: DW] : '0;
                w_q[0] <= read_q ? bus.ws_in[gi*DW +: DW] : '0;
                v_q[0] <= read_q;
                for (int j = 1; j <= gi; j++) begin
                    a_q[j] <= a_q[j-1];
                    w_q[j] <= w_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end
        end

        assign bus.a_out[gi*DW +: DW] = a_q[gi];
        assign bus.w_out[gi*DW +: DW] = w_q[gi];
        assign bus.a_vld[gi]          = v_q[gi];
        assign bus.w_vld[gi]          = v_q[gi];
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: reference model built from pop history and
// the tile timing rules, per-cycle comparison, tile table and random traffic.
module tb_systolic_skew_feeder;
    localparam int unsigned N    = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned KW   = 8;
    localparam int          MAXC = 8000;

    typedef logic [255:0] cv_t;

    typedef struct {
        string          name;
        int             k;
        int             stall_at;
        int             stall_len;
        logic [N-1:0]   am;
        logic [N-1:0]   wm;
        int             restart_at;
        int             restart_k;
        int             e_pops;
        int             e_done;
        int             e_busy;
        int             e_f0;
        int             e_f7;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.N(N), .DW(DW), .KW(KW)) bus ();

    systolic_skew_feeder #(.N(N), .DW(DW), .KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Histories indexed by cycle
    bit              read_h [MAXC];
    logic [N*DW-1:0] as_h   [MAXC];
    logic [N*DW-1:0] ws_h   [MAXC];
    int              last_rst = -1;

    // Tile model: 0 idle, 1 feeding, 2 waiting for done
    int m_phase    = 0;
    int m_k        = 0;
    int m_pops     = 0;
    int m_done_cyc = -1;
    int m_busy_end = -1;

    logic         obs_read, obs_busy, obs_done;
    logic [N-1:0] obs_avld;
    logic [2*N*DW+2*N-1:0] obs_lanes;

    task automatic chk(input string name, input cv_t act, input cv_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: compare at negedge, advance model, drive FIFO heads after posedge
    task automatic tick();
        bit              exp_read, exp_busy, exp_done;
        logic [N*DW-1:0] ea, ew;
        logic [N-1:0]    ev;
        int              p;
        @(negedge clk);
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget cyc=%0d got=%0d want<%0d", cyc, cyc, MAXC - 1);
            $fatal(1, "cycle budget exhausted");
        end
        as_h[cyc] = bus.as_in;
        ws_h[cyc] = bus.ws_in;
        exp_read  = (m_phase == 1) && (bus.aemptys == '0) && (bus.wemptys == '0);
        read_h[cyc] = exp_read;
        exp_busy  = (m_phase == 1) || (m_phase == 2 && cyc <= m_busy_end);
        exp_done  = (cyc == m_done_cyc);
        ea = '0;
        ew = '0;
        ev = '0;
        for (int i = 0; i < int'(N); i++) begin
            p = cyc - 2 - i;
            if (p >= 0 && read_h[p] && p > last_rst) begin
                ea[i*DW +: DW] = as_h[p+1][i*DW +: DW];
                ew[i*DW +: DW] = ws_h[p+1][i*DW +: DW];
                ev[i] = 1'b1;
            end
        end
        obs_read  = bus.read;
        obs_busy  = bus.busy;
        obs_done  = bus.done;
        obs_avld  = bus.a_vld;
        obs_lanes = {bus.a_out, bus.w_out, bus.a_vld, bus.w_vld};
        if (chk_en) begin
            chk("read", cv_t'(obs_read), cv_t'(exp_read));
            chk("busy", cv_t'(obs_busy), cv_t'(exp_busy));
            chk("done", cv_t'(obs_done), cv_t'(exp_done));
            chk("lanes", cv_t'(obs_lanes), cv_t'({ea, ew, ev, ev}));
        end
        if (rst) begin
            m_phase    = 0;
            m_pops     = 0;
            m_done_cyc = -1;
            m_busy_end = -1;
            last_rst   = cyc;
        end else begin
            case (m_phase)
                0: begin
                    if (bus.start) begin
                        m_k    = int'(bus.k_len);
                        m_pops = 0;
                        if (m_k == 0) begin
                            m_phase    = 2;
                            m_done_cyc = cyc + 2;
                            m_busy_end = -1;
                        end else begin
                            m_phase = 1;
                        end
                    end
                end
                1: begin
                    if (exp_read) begin
                        m_pops++;
                        if (m_pops == m_k) begin
                            m_phase    = 2;
                            m_done_cyc = cyc + int'(N) + 3;
                            m_busy_end = cyc + int'(N) + 1;
                        end
                    end
                end
                default: begin
                    if (cyc + 1 == m_done_cyc) m_phase = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < int'(N); i++) begin
            if (exp_read) bus.as_in[i*DW +: DW] = DW'(i * 16 + (m_pops % 16));
            else          bus.as_in[i*DW +: DW] = DW'($urandom);
            bus.ws_in[i*DW +: DW] = DW'($urandom);
        end
    endtask

    // Run one tile starting now; observe pops, done offset, busy length, first valid per edge lane
    task automatic run_vec(input vec_t v);
        int pops, done_off, busy_cnt, f0, f7;
        pops = 0; done_off = -1; busy_cnt = 0; f0 = -1; f7 = -1;
        for (int j = 0; j < 60; j++) begin
            if (done_off >= 0 && j > done_off + 2) break;
            bus.start = (j == 0) || (j == v.restart_at);
            bus.k_len = (j == 0) ? KW'(v.k) : ((j == v.restart_at) ? KW'(v.restart_k) : '0);
            if (j >= v.stall_at && j < v.stall_at + v.stall_len) begin
                bus.aemptys = v.am;
                bus.wemptys = v.wm;
            end else begin
                bus.aemptys = '0;
                bus.wemptys = '0;
            end
            tick();
            if (obs_read) pops++;
            if (obs_busy) busy_cnt++;
            if (obs_done && done_off < 0) done_off = j;
            if (obs_avld[0] && f0 < 0) f0 = j;
            if (obs_avld[N-1] && f7 < 0) f7 = j;
        end
        bus.start   = 1'b0;
        bus.aemptys = '0;
        bus.wemptys = '0;
        chk({v.name, ".pops"},  cv_t'(pops),     cv_t'(v.e_pops));
        chk({v.name, ".done"},  cv_t'(done_off), cv_t'(v.e_done));
        chk({v.name, ".busy"},  cv_t'(busy_cnt), cv_t'(v.e_busy));
        chk({v.name, ".first0"}, cv_t'(f0),      cv_t'(v.e_f0));
        chk({v.name, ".firstN"}, cv_t'(f7),      cv_t'(v.e_f7));
    endtask

    vec_t vecs [9];
    int   ndone;

    initial begin
        //           name             k  st ln  am     wm     rs  rk pops done busy f0 f7
        vecs[0] = '{"basic",          4, -1, 0, 8'h00, 8'h00, -1, 0, 4,  15,  13,  3, 10};
        vecs[1] = '{"stall_all",      4,  3, 2, 8'hff, 8'hff, -1, 0, 4,  17,  15,  3, 10};
        vecs[2] = '{"w5_empty",       4,  2, 3, 8'h00, 8'h20, -1, 0, 4,  18,  16,  3, 10};
        vecs[3] = '{"k0",             0, -1, 0, 8'h00, 8'h00, -1, 0, 0,   2,   0, -1, -1};
        vecs[4] = '{"k1",             1, -1, 0, 8'h00, 8'h00, -1, 0, 1,  12,  10,  3, 10};
        vecs[5] = '{"start_in_drain", 4, -1, 0, 8'h00, 8'h00,  8, 9, 4,  15,  13,  3, 10};
        vecs[6] = '{"after_drain_k9", 9, -1, 0, 8'h00, 8'h00, -1, 0, 9,  20,  18,  3, 10};
        vecs[7] = '{"start_in_done",  4, -1, 0, 8'h00, 8'h00, 14, 2, 4,  15,  13,  3, 10};
        vecs[8] = '{"first_empty",   12,  1, 1, 8'h01, 8'h00, -1, 0, 12, 24,  22,  4, 11};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.k_len   = '0;
        bus.aemptys = '0;
        bus.wemptys = '0;
        bus.as_in   = '0;
        bus.ws_in   = '0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            run_vec(vecs[v]);
            tick();
        end

        // Reset on the third pop of a k=5 tile abandons it without a done pulse
        bus.start = 1'b1;
        bus.k_len = KW'(5);
        tick();
        bus.start = 1'b0;
        bus.k_len = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst.read",  cv_t'(obs_read),  cv_t'(1'b0));
        chk("rst.busy",  cv_t'(obs_busy),  cv_t'(1'b0));
        chk("rst.lanes", cv_t'(obs_lanes), cv_t'(0));
        ndone = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (obs_done) ndone++;
        end
        chk("rst.no_done", cv_t'(ndone), cv_t'(0));
        run_vec('{"after_rst", 5, -1, 0, 8'h00, 8'h00, -1, 0, 5, 16, 14, 3, 10});

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            bus.start = ($urandom_range(0, 5) == 0);
            bus.k_len = KW'($urandom_range(0, 12));
            bus.aemptys = '0;
            bus.wemptys = '0;
            case ($urandom_range(0, 7))
                0: bus.aemptys = N'(1) << $urandom_range(0, N - 1);
                1: bus.wemptys = N'(1) << $urandom_range(0, N - 1);
                2: begin
                    bus.aemptys = N'($urandom);
                    bus.wemptys = N'($urandom);
                end
                default: begin
                end
            endcase
            tick();
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.aemptys = '0;
        bus.wemptys = '0;
        for (int j = 0; j < 30; j++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
